// File: rtl/scic_pkg.sv
// rtl/scic_pkg.sv - shared constants and state encoding for the SCIC memory responder
package scic_pkg;

    localparam int DEFAULT_RAM_WORDS = 1024;

    localparam logic [15:0] ADDR_GPIO   = 16'hFF00;
    localparam logic [15:0] ADDR_CYCLE  = 16'hFF01;
    localparam logic [15:0] ADDR_CMP    = 16'hFF02;
    localparam logic [15:0] ADDR_STATUS = 16'hFF03;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/scic_ram.sv
// rtl/scic_ram.sv - WORDS x 32 RAM, asynchronous read, single synchronous write port
module scic_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/scic_memory.sv
// rtl/scic_memory.sv - boot-loaded RAM plus GPIO/cycle-timer MMIO behind a zero-wait CPU bus
module scic_memory
    import scic_pkg::*;
#(
    parameter int RAM_WORDS = DEFAULT_RAM_WORDS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_reset,
    output logic [15:0] gpio_out,
    output logic        timer_flag
);

    localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);

    state_t      state;
    state_t      state_next;
    logic [15:0] load_ptr;
    logic        load_ovf;
    logic [31:0] cycle;
    logic [31:0] cmp;

    logic          load_accept;
    logic          load_in_range;
    logic          cpu_in_ram;
    logic          cpu_wr;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    assign load_accept   = load_valid && load_ready;
    assign load_in_range = {1'b0, load_ptr} < RAM_LIMIT;
    assign cpu_in_ram    = {1'b0, address} < RAM_LIMIT;
    assign cpu_wr        = (state == ST_RUN) && we;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (state == ST_LOAD && load_valid && load_last) begin
            state_next = ST_RUN;
        end
    end

    // Both outputs decode the single state flop, so they are glitch-free register outputs.
    always_comb begin
        cpu_reset  = (state == ST_LOAD);
        load_ready = (state == ST_LOAD);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_ptr <= '0;
            load_ovf <= 1'b0;
        end else if (load_accept) begin
            load_ptr <= load_ptr + 16'd1;
            if (!load_in_range) begin
                load_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gpio_out   <= '0;
            cycle      <= '0;
            cmp        <= CMP_RESET;
            timer_flag <= 1'b0;
        end else if (state == ST_RUN) begin
            if (cpu_wr && address == ADDR_GPIO) begin
                gpio_out <= wdata[15:0];
            end
            if (cpu_wr && address == ADDR_CMP) begin
                cmp <= wdata;
            end
            if (cpu_wr && address == ADDR_CYCLE) begin
                cycle <= wdata;
            end else begin
                cycle <= cycle + 32'd1;
            end
            // A match on the same edge as a clear-write wins.
            if (cycle == cmp) begin
                timer_flag <= 1'b1;
            end else if (cpu_wr && address == ADDR_STATUS && wdata[0]) begin
                timer_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = address[AW-1:0];
        ram_wdata = wdata;
        if (state == ST_LOAD) begin
            ram_we    = load_accept && load_in_range;
            ram_waddr = load_ptr[AW-1:0];
            ram_wdata = load_data;
        end else begin
            ram_we    = cpu_wr && cpu_in_ram;
        end
    end

    scic_ram #(
        .WORDS (RAM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (address[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_comb begin
        rdata = '0;
        if (state == ST_RUN) begin
            if (cpu_in_ram) begin
                rdata = ram_rdata;
            end else begin
                case (address)
                    ADDR_GPIO:   rdata = {16'h0, gpio_out};
                    ADDR_CYCLE:  rdata = cycle;
                    ADDR_CMP:    rdata = cmp;
                    ADDR_STATUS: rdata = {30'h0, load_ovf, timer_flag};
                    default:     rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: doc/scic_memory.md
SCIC_MEMORY -- requirements
Module: scic_memory

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024, meaning the number of 32-bit RAM words at word addresses 0..RAM_WORDS-1 (a power of 2, at most 32768).
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port address  input  16  CPU word address.
REQ-005 SHALL have port wdata  input  32  CPU write data, from the CPU data_out.
REQ-006 SHALL have port we  input  1  CPU write enable.
REQ-007 SHALL have port rdata  output  32  read data, driven to the CPU data_in.
REQ-008 SHALL have port load_valid  input  1  boot-loader word valid.
REQ-009 SHALL have port load_data  input  32  boot-loader word.
REQ-010 SHALL have port load_last  input  1  marks the final boot-loader word.
REQ-011 SHALL have port load_ready  output  1  responder accepts loader words.
REQ-012 SHALL have port cpu_reset  output  1  active-high hold of the CPU reset.
REQ-013 SHALL have port gpio_out  output  16  GPIO output register.
REQ-014 SHALL have port timer_flag  output  1  sticky timer-match flag.

Function
REQ-015 SHALL implement two states: LOAD (initial) and RUN; cpu_reset=1 and load_ready=1 in LOAD, both 0 in RUN.
REQ-016 SHALL accept a loader word on a clock edge with load_valid&load_ready, write it to RAM[load_ptr], and increment the 16-bit load_ptr (reset 0).
REQ-017 SHALL move LOAD->RUN on the edge accepting a word with load_last=1; RUN has no exit except reset.
REQ-018 SHALL discard accepted loader words when load_ptr>=RAM_WORDS, set sticky load_ovf, and still honour load_last.
REQ-019 SHALL decode the CPU bus in RUN only: RAM for address<RAM_WORDS; MMIO at 0xFF00 GPIO (bits 15:0), 0xFF01 CYCLE, 0xFF02 CMP, 0xFF03 STATUS {30'b0, load_ovf, timer_flag}.
REQ-020 SHALL drive rdata combinationally from address in the same cycle (zero-wait-state read); unmapped addresses and all addresses in LOAD read 0.
REQ-021 SHALL perform CPU writes at the clock edge with we=1 in RUN; writes in LOAD or to unmapped or read-only addresses are ignored.
REQ-022 SHALL increment CYCLE (32-bit, wraps 0xFFFFFFFF->0) every clock in RUN; a CPU write to 0xFF01 loads wdata instead of incrementing.
REQ-023 SHALL set timer_flag on any RUN edge where CYCLE==CMP before the update; a CPU write to 0xFF03 with wdata[0]=1 clears it; a set and a clear on the same edge resolve to set.
REQ-024 SHALL clear load_ovf only by reset.
REQ-025 SHALL take gpio_out, timer_flag and cpu_reset directly from registers, with no combinational path from inputs.

Reset
REQ-026 SHALL on reset=0, immediately and regardless of clock: state=LOAD, cpu_reset=1, load_ready=1, load_ptr=0, gpio_out=0, CYCLE=0, CMP=0xFFFFFFFF, timer_flag=0, load_ovf=0.
REQ-027 SHALL leave RAM contents unchanged by reset; reset during LOAD or RUN restarts loading at word 0.

Structure
REQ-028 SHALL place the MMIO address constants (0xFF00..0xFF03), the default RAM_WORDS and the LOAD/RUN state encoding in shared package scic_pkg.
REQ-029 SHALL instantiate one sub-module scic_ram: RAM_WORDS x 32, asynchronous read, synchronous single write port, with write requests muxed from the loader (LOAD) or the CPU (RUN).

Verification
REQ-030 SHALL cover boot load: words 0x40000005, 0x70000010 and 0x80000000 with load_last on the third -> RAM[0..2] hold them, cpu_reset falls on the edge after the third, load_ready=0.
REQ-031 SHALL cover bus access: in RUN, address=0x0010 with we=1 and wdata=0x12345678, then address=0x0010 with we=0 -> rdata=0x12345678 in the same cycle.
REQ-032 SHALL cover timer: write CMP=5, CYCLE=0 -> timer_flag=1 after the 6th edge; a clear-write coinciding with a second match -> flag stays 1.
REQ-033 SHALL cover overflow: RAM_WORDS=4, load 6 words with the last flagged -> RAM holds words 0-3, STATUS reads 0x2, state=RUN.
REQ-034 SHALL cover asynchronous reset: reset=0 mid-RUN between edges -> cpu_reset=1, gpio_out=0 and CYCLE=0 without a clock edge; the RAM word written in REQ-031 is retained.
REQ-035 SHALL cover bus during LOAD: we=1 to address 0x0003 -> RAM unchanged and rdata=0.
